// File: rtl/wb_data_ram.sv
// wb_data_ram: Wishbone single-port 32-bit data RAM with byte lanes and configurable wait states.
// Define WB_RAM_ERR_EN to terminate out-of-range addresses with o_wb_err instead of aliasing.
module wb_data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);
  state_t state, next;
  logic [3:0] cnt;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx_q, req_idx;
  logic [3:0] sel_q, req_sel;
  logic [31:0] dat_q, req_dat;
  logic we_q, req_we, req_oor, go, idle, enter_ack, unused;
  assign unused = ^{i_wb_adr[1:0], i_wb_adr[31:ADDR_WIDTH+2]};
  assign go = i_wb_cyc & i_wb_stb;
  assign idle = state == IDLE;
  // In IDLE the request is taken straight from the bus so a zero-wait access can complete on the latching edge.
  always_comb begin
    next = idle ? (go ? (WAIT_CYCLES == 0 ? ACK : WAIT) : IDLE)
         : state == WAIT ? (!go ? IDLE : cnt == CNT_LAST ? ACK : WAIT) : IDLE;
    enter_ack = next == ACK;
    req_idx = idle ? i_wb_adr[ADDR_WIDTH+1:2] : idx_q;
    req_we = idle ? i_wb_we : we_q;
    req_sel = idle ? i_wb_sel : sel_q;
    req_dat = idle ? i_wb_dat : dat_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      state <= next;
      cnt <= (state == WAIT && next == WAIT) ? cnt + 4'd1 : '0;
      o_wb_ack <= enter_ack & ~req_oor;
      o_wb_dat <= (enter_ack && !req_we && !req_oor) ? mem[req_idx] : '0;
    end
    if (idle) begin
      idx_q <= i_wb_adr[ADDR_WIDTH+1:2];
      we_q <= i_wb_we;
      sel_q <= i_wb_sel;
      dat_q <= i_wb_dat;
    end
  end
  always_ff @(posedge i_clk)
    if (!i_rst && enter_ack && req_we && !req_oor)
      for (int i = 0; i < 4; i++)
        if (req_sel[i]) mem[req_idx][8*i +: 8] <= req_dat[8*i +: 8];
`ifdef WB_RAM_ERR_EN
  logic oor_q;
  assign req_oor = idle ? |i_wb_adr[31:ADDR_WIDTH+2] : oor_q;
  always_ff @(posedge i_clk) begin
    if (idle) oor_q <= |i_wb_adr[31:ADDR_WIDTH+2];
    o_wb_err <= !i_rst && enter_ack && req_oor;
  end
`else
  assign req_oor = 1'b0;
  assign o_wb_err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_data_ram.sv
// tb_wb_data_ram: randomized self-checking bench for wb_data_ram, one instance with one wait state and one with none.
module tb_wb_data_ram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic cyc[2], stb[2], we[2], ack[2], err[2];
  logic [31:0] adr[2], wdat[2], rdat[2];
  logic [3:0] sel[2];
  logic [31:0] mdl[2][16];
  int checks = 0, failures = 0;
  localparam int wc[2] = '{1, 0};
`ifdef WB_RAM_ERR_EN
  localparam bit err_en = 1'b1;
`else
  localparam bit err_en = 1'b0;
`endif
  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_data_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(g == 0 ? 1 : 0)) dut (
      .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc[g]), .i_wb_stb(stb[g]), .i_wb_we(we[g]),
      .i_wb_adr(adr[g]), .i_wb_sel(sel[g]), .i_wb_dat(wdat[g]),
      .o_wb_dat(rdat[g]), .o_wb_ack(ack[g]), .o_wb_err(err[g])
    );
  end
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask
  task automatic xfer(int d, bit w, logic [31:0] a, logic [3:0] s, logic [31:0] wd, bit exp_err,
                      output logic [31:0] rd);
    int n;
    bit done;
    n = 0;
    done = 0;
    @(posedge clk); #1;
    cyc[d] = 1; stb[d] = 1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = wd;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[d] || err[d]) done = 1;
      else check("dat_low", rdat[d], 32'd0);
    end
    cyc[d] = 0; stb[d] = 0;
    check("latency", n, 2 + wc[d]);
    check("ack", ack[d], !exp_err);
    check("err", err[d], exp_err);
    rd = rdat[d];
  endtask
  task automatic op(int d, bit w, int i, logic [19:0] hi, logic [3:0] s, logic [31:0] wd);
    logic [31:0] a, rd, mask;
    bit oor;
    a = {hi, 6'd0, i[3:0], 2'($urandom)};
    oor = err_en && hi != 0;
    mask = 0;
    for (int b = 0; b < 4; b++) if (s[b]) mask |= 32'hFF << (8 * b);
    xfer(d, w, a, s, wd, oor, rd);
    if (w && !oor) mdl[d][i] = (mdl[d][i] & ~mask) | (wd & mask);
    if (!w) check("rdata", rd, oor ? 32'd0 : mdl[d][i]);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    int acks;
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = 0; sel[d] = 0; wdat[d] = 0;
      for (int i = 0; i < 16; i++) mdl[d][i] = 0;
    end
    cyc[0] = 1; stb[0] = 1;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("rst_ack", ack[d], 0);
        check("rst_err", err[d], 0);
        check("rst_dat", rdat[d], 0);
      end
    end
    @(posedge clk); #1;
    cyc[0] = 0; stb[0] = 0; rst = 0;
    xfer(0, 1, 32'h10, 4'hF, 32'h12345678, 0, rd);
    xfer(0, 0, 32'h10, 4'hF, 0, 0, rd);
    check("basic_rd", rd, 32'h12345678);
    xfer(0, 1, 32'h20, 4'hF, 32'hAABBCCDD, 0, rd);
    xfer(0, 1, 32'h20, 4'h1, 32'h00000011, 0, rd);
    xfer(0, 0, 32'h20, 4'hF, 0, 0, rd);
    check("lane0_rd", rd, 32'hAABBCC11);
    xfer(0, 1, 32'h20, 4'h0, 32'hFFFFFFFF, 0, rd);
    xfer(0, 0, 32'h20, 4'hF, 0, 0, rd);
    check("sel0_rd", rd, 32'hAABBCC11);
    @(posedge clk); #1;
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h10; sel[0] = 4'hF; wdat[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    rst = 1;
    acks = 0;
    @(negedge clk); acks += ack[0];
    @(posedge clk); #1;
    rst = 0; cyc[0] = 0; stb[0] = 0;
    repeat (4) begin @(negedge clk); acks += ack[0] + err[0]; end
    check("rst_abort_ack", acks, 0);
    xfer(0, 0, 32'h10, 4'hF, 0, 0, rd);
    check("rst_abort_rd", rd, 32'h12345678);
    @(posedge clk); #1;
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'h10; sel[0] = 4'hF; wdat[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    cyc[0] = 0; stb[0] = 0;
    acks = 0;
    repeat (4) begin @(negedge clk); acks += ack[0] + err[0]; end
    check("drop_ack", acks, 0);
    xfer(0, 0, 32'h10, 4'hF, 0, 0, rd);
    check("drop_rd", rd, 32'h12345678);
    xfer(0, 1, 32'h1010, 4'hF, 32'hCAFEF00D, err_en, rd);
    xfer(0, 0, 32'h10, 4'hF, 0, 0, rd);
    check("alias_rd", rd, err_en ? 32'h12345678 : 32'hCAFEF00D);
    xfer(1, 1, 32'h10, 4'hF, 32'h5A5AA5A5, 0, rd);
    @(posedge clk); #1;
    cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h10; sel[1] = 4'hF;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      check("b2b_ack", ack[1], n % 2 == 0);
      check("b2b_dat", rdat[1], n % 2 == 0 ? 32'h5A5AA5A5 : 32'd0);
    end
    cyc[1] = 0; stb[1] = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) op(d, 1, i, 20'd0, 4'hF, $urandom);
    for (int k = 0; k < 160; k++) begin
      op(k % 2, 1'($urandom), $urandom_range(0, 15),
         $urandom_range(0, 3) == 0 ? 20'($urandom) : 20'd0, 4'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_data_ram.md
WB_DATA_RAM -- requirements
Module: wb_data_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-address bits (1024 x 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning wait states inserted before acknowledge (legal range 0..15).
REQ-003 SHALL have port i_clk  input  1  meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port i_wb_cyc  input  1  meaning bus cycle active.
REQ-006 SHALL have port i_wb_stb  input  1  meaning strobe; request valid.
REQ-007 SHALL have port i_wb_we  input  1  meaning 1 = write, 0 = read.
REQ-008 SHALL have port i_wb_adr  input  32  meaning byte address; bits [1:0] ignored.
REQ-009 SHALL have port i_wb_sel  input  4  meaning byte lane enables; bit n covers data[8n+7:8n].
REQ-010 SHALL have port i_wb_dat  input  32  meaning write data.
REQ-011 SHALL have port o_wb_dat  output  32  meaning read data.
REQ-012 SHALL have port o_wb_ack  output  1  meaning transfer complete, one-cycle pulse.
REQ-013 SHALL have port o_wb_err  output  1  meaning error termination; tied 0 unless WB_RAM_ERR_EN is defined.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-015 In IDLE, cyc&stb high at a rising edge SHALL latch adr/we/sel/dat and go to WAIT (WAIT_CYCLES>0) or ACK (WAIT_CYCLES=0).
REQ-016 WAIT SHALL count WAIT_CYCLES cycles, then enter ACK; total latency = 1+WAIT_CYCLES cycles from first strobe cycle to ack cycle.
REQ-017 ACK SHALL last exactly one cycle, then return to IDLE; minimum spacing between acks is 2+WAIT_CYCLES cycles.
REQ-018 A write SHALL update only the byte lanes with sel=1, committed on the edge entering ACK; sel=4'b0000 write SHALL still ack and change nothing.
REQ-019 A read SHALL drive the full addressed word on o_wb_dat during the ACK cycle, including bytes written by an immediately preceding write.
REQ-020 o_wb_dat SHALL be 0 in every cycle where o_wb_ack is low.
REQ-021 Word index SHALL be i_wb_adr[ADDR_WIDTH+1:2]; with WB_RAM_ERR_EN undefined, upper address bits SHALL be ignored (aliasing wrap-around).
REQ-022 If cyc or stb drops while in WAIT, the FSM SHALL abort to IDLE with no write and no ack/err.
REQ-023 In the cycle after ACK, the FSM is in IDLE; a still-high stb there SHALL be treated as a new request.

Reset
REQ-024 i_rst high at a rising edge SHALL force IDLE, clear wait counter, o_wb_ack=0, o_wb_err=0, o_wb_dat=0, overriding any request in the same cycle.
REQ-025 Reset mid-transaction SHALL discard the transaction: no write committed, no ack issued.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro WB_RAM_ERR_EN defined: a request with i_wb_adr[31:ADDR_WIDTH+2] non-zero SHALL follow the same FSM timing but pulse o_wb_err instead of o_wb_ack, with no memory write and o_wb_dat=0.
REQ-028 Macro WB_RAM_ERR_EN undefined: o_wb_err SHALL be constant 0 and out-of-range addresses alias per REQ-021.

Verification
REQ-029 Write 0x12345678 to 0x0000_0010, sel=4'hF, WAIT_CYCLES=1, then read 0x10 -> ack 2 cycles after each strobe, read data 0x12345678.
REQ-030 Preload 0xAABBCCDD at 0x20, write 0x00000011 sel=4'b0001, read -> 0xAABBCC11; write sel=4'b0000 -> read still 0xAABBCC11.
REQ-031 WAIT_CYCLES=0, back-to-back reads with stb held high -> ack every 2nd cycle, o_wb_dat=0 between acks.
REQ-032 Write 0xDEADBEEF, assert i_rst during WAIT -> no ack; subsequent read of that address returns old contents.
REQ-033 Drop stb during WAIT on write -> no ack, memory unchanged; next request completes normally.
REQ-034 Address 0x0000_1010 (ADDR_WIDTH=10): with WB_RAM_ERR_EN -> o_wb_err pulse, no ack, no write; without -> ack, aliases word 0x10.
